// File: rtl/arp_pkg.sv
// Shared widths, table entry layout and state encodings for the ARP table arbiter.
package arp_pkg;

    localparam int NUM_ENTRIES = 32;
    localparam int IDX_WIDTH   = 5;
    localparam int IP_WIDTH    = 32;
    localparam int MAC_WIDTH   = 48;
    localparam int OQ_WIDTH    = 8;
    localparam int ENTRY_WIDTH = 1 + IP_WIDTH + MAC_WIDTH;
    localparam int AGE_WIDTH   = 8;

    localparam int DEF_AGE_TICK_CYCLES = 100000000;
    localparam int DEF_AGE_MAX         = 255;

    typedef struct packed {
        logic                 vld;
        logic [IP_WIDTH-1:0]  ip;
        logic [MAC_WIDTH-1:0] mac;
    } arp_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        RESP
    } arp_state_e;

    typedef enum logic {
        GNT_LKUP,
        GNT_MGMT
    } arp_grant_e;

endpackage

// File: rtl/arp_match_prio_enc.sv
// Parallel compare of the lookup IP against every table entry; the lowest matching index wins.
module arp_match_prio_enc
    import arp_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] tab_vld,
    input  logic [IP_WIDTH-1:0]    tab_ip [NUM_ENTRIES],
    input  logic [IP_WIDTH-1:0]    ip,
    output logic                   hit,
    output logic [IDX_WIDTH-1:0]   index
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that leaves one unassigned infers a latch.
        hit   = 1'b0;
        index = '0;
        // Scanning downwards lets the lowest matching index overwrite any higher one.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (tab_vld[i] && (tab_ip[i] == ip)) begin
                hit   = 1'b1;
                index = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/arp_table_arbiter.sv
// Next-hop ARP table shared by the LPM lookup port and the management write/read port.
// Entry aging (prescaler + per-entry age) is compiled in only when ARP_AGING_EN is defined.
module arp_table_arbiter
    import arp_pkg::*;
`ifdef ARP_AGING_EN
#(
    parameter int AGE_TICK_CYCLES = DEF_AGE_TICK_CYCLES,
    parameter int AGE_MAX         = DEF_AGE_MAX
)
`endif
(
    input  logic                   AXI_ACLK,
    input  logic                   AXI_RESETN,
    input  logic                   lkup_req_valid,
    output logic                   lkup_req_ready,
    input  logic [IP_WIDTH-1:0]    lkup_req_ip,
    input  logic [OQ_WIDTH-1:0]    lkup_req_oq,
    output logic                   lkup_rsp_valid,
    output logic                   lkup_rsp_hit,
    output logic [MAC_WIDTH-1:0]   lkup_rsp_mac,
    output logic [OQ_WIDTH-1:0]    lkup_rsp_oq,
    output logic [IDX_WIDTH-1:0]   lkup_rsp_index,
    input  logic                   mgmt_wr_req,
    output logic                   mgmt_wr_ack,
    input  logic [IDX_WIDTH-1:0]   mgmt_wr_index,
    input  logic [IP_WIDTH-1:0]    mgmt_wr_ip,
    input  logic [MAC_WIDTH-1:0]   mgmt_wr_mac,
    input  logic                   mgmt_wr_vld,
    input  logic [IDX_WIDTH-1:0]   mgmt_rd_index,
    output logic [ENTRY_WIDTH-1:0] mgmt_rd_entry,
    output logic [31:0]            arp_hit_count,
    output logic [31:0]            arp_miss_count
);

    arp_state_e           state_q, state_d;
    arp_grant_e           last_grant_q;
    logic                 run_q;
    logic                 in_idle, is_match;
    logic                 wr_want, wr_grant, lk_grant;
    logic [IP_WIDTH-1:0]  req_ip_q;
    logic [OQ_WIDTH-1:0]  req_oq_q;
    logic [31:0]          hit_cnt, miss_cnt;

    arp_entry_t           table_q [NUM_ENTRIES];
    arp_entry_t           table_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] tab_vld;
    logic [IP_WIDTH-1:0]  tab_ip [NUM_ENTRIES];
    logic                 m_hit;
    logic [IDX_WIDTH-1:0] m_idx;

    // run_q holds ready low while reset is asserted and for the first clock after release.
    assign in_idle        = run_q && (state_q == IDLE);
    assign is_match       = (state_q == MATCH);
    assign wr_want        = mgmt_wr_req && !mgmt_wr_ack;
    assign lkup_req_ready = in_idle && !wr_grant;
    assign arp_hit_count  = hit_cnt;
    assign arp_miss_count = miss_cnt;

    always_comb begin
        wr_grant = 1'b0;
        lk_grant = 1'b0;
        state_d  = state_q;
        if (in_idle) begin
            if (wr_want && lkup_req_valid) begin
                lk_grant = (last_grant_q == GNT_MGMT);
                wr_grant = !lk_grant;
            end else begin
                wr_grant = wr_want;
                lk_grant = lkup_req_valid;
            end
        end
        case (state_q)
            IDLE:    if (lk_grant) state_d = MATCH;
            MATCH:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            tab_vld[i] = table_q[i].vld;
            tab_ip[i]  = table_q[i].ip;
        end
    end

    arp_match_prio_enc u_match (
        .tab_vld (tab_vld),
        .tab_ip  (tab_ip),
        .ip      (req_ip_q),
        .hit     (m_hit),
        .index   (m_idx)
    );

`ifdef ARP_AGING_EN
    localparam int                   PS_W    = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
    localparam logic [PS_W-1:0]      PS_LAST = PS_W'(AGE_TICK_CYCLES - 1);
    localparam logic [AGE_WIDTH-1:0] AGE_LIM = AGE_WIDTH'(AGE_MAX);

    logic [PS_W-1:0]      ps_q;
    logic                 age_tick;
    logic [AGE_WIDTH-1:0] age_q [NUM_ENTRIES];
    logic [AGE_WIDTH-1:0] age_d [NUM_ENTRIES];

    assign age_tick = (ps_q == PS_LAST);

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            ps_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= '0;
        end else begin
            ps_q <= age_tick ? '0 : ps_q + 1'b1;
            for (int i = 0; i < NUM_ENTRIES; i++) age_q[i] <= age_d[i];
        end
    end
`endif

    // Next table image; the management read port samples it so a same-edge write is visible.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            table_d[i] = table_q[i];
`ifdef ARP_AGING_EN
            age_d[i] = age_q[i];
            if (is_match && m_hit && (m_idx == IDX_WIDTH'(i))) begin
                age_d[i] = '0;
            end else if (age_tick && table_q[i].vld) begin
                age_d[i] = age_q[i] + 1'b1;
                if (age_q[i] + 1'b1 == AGE_LIM) table_d[i].vld = 1'b0;
            end
`endif
        end
        if (wr_grant) begin
            table_d[mgmt_wr_index] = '{vld: mgmt_wr_vld, ip: mgmt_wr_ip, mac: mgmt_wr_mac};
`ifdef ARP_AGING_EN
            age_d[mgmt_wr_index] = '0;
`endif
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        // NOTE: the table is a flop array rather than a RAM macro, so it is reset like any register.
        if (!AXI_RESETN) begin
            for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= table_d[i];
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q        <= IDLE;
            last_grant_q   <= GNT_MGMT;
            run_q          <= 1'b0;
            req_ip_q       <= '0;
            req_oq_q       <= '0;
            mgmt_wr_ack    <= 1'b0;
            lkup_rsp_valid <= 1'b0;
            lkup_rsp_hit   <= 1'b0;
            lkup_rsp_mac   <= '0;
            lkup_rsp_oq    <= '0;
            lkup_rsp_index <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            mgmt_rd_entry  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            run_q       <= 1'b1;
            mgmt_wr_ack <= wr_grant;
            if (wr_grant) begin
                last_grant_q <= GNT_MGMT;
            end else if (lk_grant) begin
                last_grant_q <= GNT_LKUP;
                req_ip_q     <= lkup_req_ip;
                req_oq_q     <= lkup_req_oq;
            end
            lkup_rsp_valid <= is_match;
            lkup_rsp_hit   <= is_match && m_hit;
            lkup_rsp_mac   <= (is_match && m_hit) ? table_q[m_idx].mac : '0;
            lkup_rsp_oq    <= is_match ? req_oq_q : '0;
            lkup_rsp_index <= (is_match && m_hit) ? m_idx : '0;
            if (is_match && m_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
            if (is_match && !m_hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
            mgmt_rd_entry <= table_d[mgmt_rd_index];
        end
    end

endmodule

// File: tb/tb_arp_table_arbiter.sv
// Scoreboard bench for arp_table_arbiter: lookups push expected responses, a monitor pops and compares.
module tb_arp_table_arbiter;
    import arp_pkg::*;

    logic                   AXI_ACLK;
    logic                   AXI_RESETN;
    logic                   lkup_req_valid;
    logic                   lkup_req_ready;
    logic [IP_WIDTH-1:0]    lkup_req_ip;
    logic [OQ_WIDTH-1:0]    lkup_req_oq;
    logic                   lkup_rsp_valid;
    logic                   lkup_rsp_hit;
    logic [MAC_WIDTH-1:0]   lkup_rsp_mac;
    logic [OQ_WIDTH-1:0]    lkup_rsp_oq;
    logic [IDX_WIDTH-1:0]   lkup_rsp_index;
    logic                   mgmt_wr_req;
    logic                   mgmt_wr_ack;
    logic [IDX_WIDTH-1:0]   mgmt_wr_index;
    logic [IP_WIDTH-1:0]    mgmt_wr_ip;
    logic [MAC_WIDTH-1:0]   mgmt_wr_mac;
    logic                   mgmt_wr_vld;
    logic [IDX_WIDTH-1:0]   mgmt_rd_index;
    logic [ENTRY_WIDTH-1:0] mgmt_rd_entry;
    logic [31:0]            arp_hit_count;
    logic [31:0]            arp_miss_count;

    arp_table_arbiter dut (
        .AXI_ACLK       (AXI_ACLK),
        .AXI_RESETN     (AXI_RESETN),
        .lkup_req_valid (lkup_req_valid),
        .lkup_req_ready (lkup_req_ready),
        .lkup_req_ip    (lkup_req_ip),
        .lkup_req_oq    (lkup_req_oq),
        .lkup_rsp_valid (lkup_rsp_valid),
        .lkup_rsp_hit   (lkup_rsp_hit),
        .lkup_rsp_mac   (lkup_rsp_mac),
        .lkup_rsp_oq    (lkup_rsp_oq),
        .lkup_rsp_index (lkup_rsp_index),
        .mgmt_wr_req    (mgmt_wr_req),
        .mgmt_wr_ack    (mgmt_wr_ack),
        .mgmt_wr_index  (mgmt_wr_index),
        .mgmt_wr_ip     (mgmt_wr_ip),
        .mgmt_wr_mac    (mgmt_wr_mac),
        .mgmt_wr_vld    (mgmt_wr_vld),
        .mgmt_rd_index  (mgmt_rd_index),
        .mgmt_rd_entry  (mgmt_rd_entry),
        .arp_hit_count  (arp_hit_count),
        .arp_miss_count (arp_miss_count)
    );

    typedef struct {
        logic                 hit;
        logic [IDX_WIDTH-1:0] idx;
        logic [MAC_WIDTH-1:0] mac;
        logic [OQ_WIDTH-1:0]  oq;
        int                   due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   a1, a2, iss, ackc;

    initial begin
        AXI_ACLK = 1'b0;
        forever #5 AXI_ACLK = ~AXI_ACLK;
    end

    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitor; the consumer samples the pulse at the edge after this negedge.
    always @(negedge AXI_ACLK) begin
        if (lkup_rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got valid=1 want no response");
            end else begin
                mon_e = sb.pop_front();
                check("rsp_hit",     128'(lkup_rsp_hit),   128'(mon_e.hit));
                check("rsp_index",   128'(lkup_rsp_index), 128'(mon_e.idx));
                check("rsp_mac",     128'(lkup_rsp_mac),   128'(mon_e.mac));
                check("rsp_oq",      128'(lkup_rsp_oq),    128'(mon_e.oq));
                check("rsp_latency", 128'(cyc + 1),        128'(mon_e.due));
            end
        end
    end

    task automatic lookup(input logic [IP_WIDTH-1:0] ip, input logic [OQ_WIDTH-1:0] oq,
                          input bit expect_rsp, input logic exp_hit,
                          input logic [IDX_WIDTH-1:0] exp_idx, input logic [MAC_WIDTH-1:0] exp_mac,
                          output int acc);
        int   n;
        exp_t e;
        acc = -1;
        @(negedge AXI_ACLK);
        lkup_req_valid = 1'b1;
        lkup_req_ip    = ip;
        lkup_req_oq    = oq;
        #1;
        n = 0;
        while (!lkup_req_ready && n < 30) begin
            @(negedge AXI_ACLK);
            #1;
            n++;
        end
        if (!lkup_req_ready) begin
            total++;
            bad++;
            $display("FAIL lkup_accept_timeout: ready=0 want 1");
            lkup_req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (expect_rsp) begin
            e = '{hit: exp_hit, idx: exp_idx, mac: exp_mac, oq: oq, due: acc + 2};
            sb.push_back(e);
        end
        @(negedge AXI_ACLK);
        lkup_req_valid = 1'b0;
    endtask

    task automatic write_entry(input logic [IDX_WIDTH-1:0] idx, input logic vld,
                               input logic [IP_WIDTH-1:0] ip, input logic [MAC_WIDTH-1:0] mac,
                               output int issue_cyc, output int ack_cyc);
        @(negedge AXI_ACLK);
        mgmt_wr_req   = 1'b1;
        mgmt_wr_index = idx;
        mgmt_wr_vld   = vld;
        mgmt_wr_ip    = ip;
        mgmt_wr_mac   = mac;
        mgmt_rd_index = idx;
        issue_cyc     = cyc;
        ack_cyc       = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge AXI_ACLK);
            if (mgmt_wr_ack) break;
        end
        if (!mgmt_wr_ack) begin
            total++;
            bad++;
            $display("FAIL wr_ack_timeout: ack=0 want 1");
            mgmt_wr_req = 1'b0;
            return;
        end
        ack_cyc     = cyc;
        mgmt_wr_req = 1'b0;
        check("rd_after_wr_vld", 128'(mgmt_rd_entry[ENTRY_WIDTH-1]),              128'(vld));
        check("rd_after_wr_ip",  128'(mgmt_rd_entry[MAC_WIDTH +: IP_WIDTH]),      128'(ip));
        check("rd_after_wr_mac", 128'(mgmt_rd_entry[MAC_WIDTH-1:0]),              128'(mac));
        @(negedge AXI_ACLK);
        check("wr_ack_pulse", 128'(mgmt_wr_ack), 128'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            @(negedge AXI_ACLK);
            #1;
            if (sb.size() == 0) break;
        end
        check("rsp_drain", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        AXI_RESETN     = 1'b0;
        lkup_req_valid = 1'b0;
        lkup_req_ip    = '0;
        lkup_req_oq    = '0;
        mgmt_wr_req    = 1'b0;
        mgmt_wr_index  = '0;
        mgmt_wr_ip     = '0;
        mgmt_wr_mac    = '0;
        mgmt_wr_vld    = 1'b0;
        mgmt_rd_index  = '0;

        repeat (3) @(negedge AXI_ACLK);
        check("reset_ready",     128'(lkup_req_ready), 128'd0);
        check("reset_rsp_valid", 128'(lkup_rsp_valid), 128'd0);
        check("reset_wr_ack",    128'(mgmt_wr_ack),    128'd0);
        check("reset_hit_cnt",   128'(arp_hit_count),  128'd0);
        check("reset_miss_cnt",  128'(arp_miss_count), 128'd0);
        check("reset_rd_entry",  128'(mgmt_rd_entry),  128'd0);
        AXI_RESETN = 1'b1;
        repeat (2) @(negedge AXI_ACLK);

        // Empty table: miss.
        lookup(32'h0A00_0001, 8'h01, 1'b1, 1'b0, 5'd0, 48'h0, a1);
        drain();
        check("miss_cnt_1", 128'(arp_miss_count), 128'd1);
        check("hit_cnt_0",  128'(arp_hit_count),  128'd0);

        write_entry(5'd3, 1'b1, 32'h0A00_0001, 48'h0011_2233_4455, iss, ackc);
        lookup(32'h0A00_0001, 8'h04, 1'b1, 1'b1, 5'd3, 48'h0011_2233_4455, a1);
        drain();
        check("hit_cnt_1", 128'(arp_hit_count), 128'd1);

        // Duplicate IP: lowest index wins until it is invalidated.
        write_entry(5'd7, 1'b1, 32'h0A00_0002, 48'h0000_AAAA_0007, iss, ackc);
        write_entry(5'd2, 1'b1, 32'h0A00_0002, 48'h0000_BBBB_0002, iss, ackc);
        lookup(32'h0A00_0002, 8'h10, 1'b1, 1'b1, 5'd2, 48'h0000_BBBB_0002, a1);
        write_entry(5'd2, 1'b0, 32'h0A00_0002, 48'h0000_BBBB_0002, iss, ackc);
        lookup(32'h0A00_0002, 8'h20, 1'b1, 1'b1, 5'd7, 48'h0000_AAAA_0007, a1);

        // Index boundaries 0 and 31.
        write_entry(5'd31, 1'b1, 32'hC0A8_0001, 48'hFEDC_BA98_7654, iss, ackc);
        write_entry(5'd0,  1'b1, 32'hC0A8_0001, 48'h1111_1111_1111, iss, ackc);
        lookup(32'hC0A8_0001, 8'h40, 1'b1, 1'b1, 5'd0, 48'h1111_1111_1111, a1);
        write_entry(5'd0,  1'b0, 32'hC0A8_0001, 48'h1111_1111_1111, iss, ackc);
        lookup(32'hC0A8_0001, 8'h80, 1'b1, 1'b1, 5'd31, 48'hFEDC_BA98_7654, a1);

        // Back-to-back lookups: one accept every 3 cycles.
        lookup(32'h0A00_0003, 8'h02, 1'b1, 1'b0, 5'd0, 48'h0, a1);
        lookup(32'h0A00_0001, 8'h08, 1'b1, 1'b1, 5'd3, 48'h0011_2233_4455, a2);
        check("lkup_throughput", 128'(a2 - a1), 128'd3);
        drain();
        check("hit_cnt_6",  128'(arp_hit_count),  128'd6);
        check("miss_cnt_2", 128'(arp_miss_count), 128'd2);

        // Miss counter saturation.
        @(negedge AXI_ACLK);
        force dut.miss_cnt = 32'hFFFF_FFFE;
        @(negedge AXI_ACLK);
        release dut.miss_cnt;
        #1;
        check("miss_cnt_preset", 128'(arp_miss_count), 128'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            lookup(32'hDEAD_0000 + k, 8'h01, 1'b1, 1'b0, 5'd0, 48'h0, a1);
            drain();
            check("miss_cnt_sat", 128'(arp_miss_count), 128'hFFFF_FFFF);
        end

        // Reset in the middle of a lookup: no response may follow.
        lookup(32'h0A00_0001, 8'h01, 1'b0, 1'b0, 5'd0, 48'h0, a1);
        AXI_RESETN = 1'b0;
        #1;
        check("midrst_rsp_valid", 128'(lkup_rsp_valid), 128'd0);
        check("midrst_ready",     128'(lkup_req_ready), 128'd0);
        check("midrst_miss_cnt",  128'(arp_miss_count), 128'd0);
        check("midrst_hit_cnt",   128'(arp_hit_count),  128'd0);
        repeat (2) @(negedge AXI_ACLK);
        AXI_RESETN    = 1'b1;
        mgmt_rd_index = 5'd3;
        repeat (6) @(negedge AXI_ACLK);
        check("midrst_table_clear", 128'(mgmt_rd_entry), 128'd0);

        // Simultaneous requests after reset: lookup first, then write, then the next lookup.
        fork
            begin
                lookup(32'h0A0A_0A0A, 8'h02, 1'b1, 1'b0, 5'd0, 48'h0, a1);
                lookup(32'h0A0A_0A0A, 8'h08, 1'b1, 1'b1, 5'd5, 48'h5555_6666_7777, a2);
            end
            begin
                write_entry(5'd5, 1'b1, 32'h0A0A_0A0A, 48'h5555_6666_7777, iss, ackc);
            end
        join
        check("arb_lkup_first",  128'(a1 - iss), 128'd1);
        check("arb_wr_ack_le4",  128'((ackc - iss) <= 4), 128'd1);
        check("arb_alternate",   128'(a2 - ackc), 128'd1);
        drain();
        check("arb_hit_cnt",  128'(arp_hit_count),  128'd1);
        check("arb_miss_cnt", 128'(arp_miss_count), 128'd1);

        repeat (4) @(negedge AXI_ACLK);
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
